// File: rtl/gemm_pkg.sv
// Shared definitions for the single-MAC GEMM engine.
//   - default widths for data, accumulator, SRAM addresses and size inputs
//   - FSM state encoding
//   - loop-counter struct holding the (m, n, k) issue position
package gemm_pkg;

    localparam int unsigned DefInDataWidth   = 8;
    localparam int unsigned DefOutDataWidth  = 32;
    localparam int unsigned DefAddrWidth     = 12;
    localparam int unsigned DefSizeAddrWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } gemm_state_e;

    // One field per loop level; k is the innermost (reduction) index.
    typedef struct packed {
        logic [DefSizeAddrWidth-1:0] m;
        logic [DefSizeAddrWidth-1:0] n;
        logic [DefSizeAddrWidth-1:0] k;
    } loop_cnt_t;

endpackage

// File: rtl/gemm_mac_pe.sv
// Signed multiply-accumulate element.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   valid_i       a/b operands are live this cycle; accumulator updates
//   first_i       first term of a dot product: accumulate onto zero
//   a_i, b_i      signed operands
//   sum_o         combinational running sum including this cycle's product
module gemm_mac_pe #(
    parameter int unsigned InDataWidth  = 8,
    parameter int unsigned OutDataWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic                    first_i,
    input  logic [InDataWidth-1:0]  a_i,
    input  logic [InDataWidth-1:0]  b_i,
    output logic [OutDataWidth-1:0] sum_o
);

    localparam int unsigned ProdWidth = 2 * InDataWidth;

    logic signed [ProdWidth-1:0]    prod;
    logic        [OutDataWidth-1:0] prod_ext;
    logic        [OutDataWidth-1:0] acc_base;
    logic        [OutDataWidth-1:0] sum;
    logic        [OutDataWidth-1:0] acc_q;

    always_comb begin
        prod     = $signed(a_i) * $signed(b_i);
        prod_ext = {{(OutDataWidth - ProdWidth){prod[ProdWidth-1]}}, prod};
        // Clearing on the first term avoids a separate clear cycle between outputs.
        acc_base = first_i ? '0 : acc_q;
        // Two's complement: unsigned add wraps identically to signed add.
        sum      = acc_base + prod_ext;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (valid_i) begin
            acc_q <= sum;
        end
    end

    assign sum_o = sum;

endmodule

// File: rtl/gemm_one_mac_accelerator.sv
// Single-MAC integer GEMM engine: C[M][N] = A[M][K] * B[K][N], row-major SRAMs.
// Issues one (m, n, k) triple per cycle, accumulates across k and writes each C
// element once when its last k term arrives.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      start pulse, honoured only in idle
//   M_size_i, K_size_i, N_size_i matrix sizes, latched on accepted start
//   sram_a_addr_o, sram_a_rdata_i  A read port (data one cycle after address)
//   sram_b_addr_o, sram_b_rdata_i  B read port (data one cycle after address)
//   sram_c_addr_o, sram_c_wdata_o, sram_c_we_o  C write port
//   done_o                       one-cycle pulse after the last C write
module gemm_one_mac_accelerator
    import gemm_pkg::*;
#(
    parameter int unsigned InDataWidth   = DefInDataWidth,
    parameter int unsigned OutDataWidth  = DefOutDataWidth,
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned SizeAddrWidth = DefSizeAddrWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    input  logic [InDataWidth-1:0]   sram_a_rdata_i,
    input  logic [InDataWidth-1:0]   sram_b_rdata_i,
    output logic [OutDataWidth-1:0]  sram_c_wdata_o,
    output logic                     sram_c_we_o,
    output logic                     done_o
);

    // The loop-counter struct is sized by the package, so the size width is fixed to it.
    if (SizeAddrWidth != DefSizeAddrWidth) begin : g_size_width_check
        $error("SizeAddrWidth must equal gemm_pkg::DefSizeAddrWidth");
    end

    // Wide enough for m*K + k without overflow before truncation to AddrWidth.
    localparam int unsigned FullAddrWidth = 2 * SizeAddrWidth + 1;

    gemm_state_e              state_q;
    logic [SizeAddrWidth-1:0] m_size_q;
    logic [SizeAddrWidth-1:0] k_size_q;
    logic [SizeAddrWidth-1:0] n_size_q;
    loop_cnt_t                cnt_q;

    // Issue tags delayed one cycle to line up with the registered SRAM reads.
    logic                     vld_q;
    logic                     first_q;
    logic                     last_q;
    logic [SizeAddrWidth-1:0] tag_m_q;
    logic [SizeAddrWidth-1:0] tag_n_q;

    logic                     k_last;
    logic                     n_last;
    logic                     m_last;
    logic                     any_size_zero;

    logic [FullAddrWidth-1:0] a_addr_full;
    logic [FullAddrWidth-1:0] b_addr_full;
    logic [FullAddrWidth-1:0] c_addr_full;
    logic [OutDataWidth-1:0]  mac_sum;
    logic                     c_we;

    always_comb begin
        k_last        = (cnt_q.k == k_size_q - SizeAddrWidth'(1));
        n_last        = (cnt_q.n == n_size_q - SizeAddrWidth'(1));
        m_last        = (cnt_q.m == m_size_q - SizeAddrWidth'(1));
        any_size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            m_size_q <= '0;
            k_size_q <= '0;
            n_size_q <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            tag_m_q  <= '0;
            tag_n_q  <= '0;
        end else begin
            vld_q   <= (state_q == StRun);
            first_q <= (cnt_q.k == '0);
            last_q  <= k_last;
            tag_m_q <= cnt_q.m;
            tag_n_q <= cnt_q.n;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        m_size_q <= M_size_i;
                        k_size_q <= K_size_i;
                        n_size_q <= N_size_i;
                        cnt_q    <= '0;
                        state_q  <= any_size_zero ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (!k_last) begin
                        cnt_q.k <= cnt_q.k + SizeAddrWidth'(1);
                    end else begin
                        cnt_q.k <= '0;
                        if (!n_last) begin
                            cnt_q.n <= cnt_q.n + SizeAddrWidth'(1);
                        end else begin
                            cnt_q.n <= '0;
                            if (!m_last) begin
                                cnt_q.m <= cnt_q.m + SizeAddrWidth'(1);
                            end else begin
                                cnt_q.m <= '0;
                                state_q <= StDrain;
                            end
                        end
                    end
                end
                StDrain: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        a_addr_full = FullAddrWidth'(cnt_q.m) * FullAddrWidth'(k_size_q)
                    + FullAddrWidth'(cnt_q.k);
        b_addr_full = FullAddrWidth'(cnt_q.k) * FullAddrWidth'(n_size_q)
                    + FullAddrWidth'(cnt_q.n);
        c_addr_full = FullAddrWidth'(tag_m_q) * FullAddrWidth'(n_size_q)
                    + FullAddrWidth'(tag_n_q);
    end

    gemm_mac_pe #(
        .InDataWidth  (InDataWidth),
        .OutDataWidth (OutDataWidth)
    ) u_mac_pe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld_q),
        .first_i (first_q),
        .a_i     (sram_a_rdata_i),
        .b_i     (sram_b_rdata_i),
        .sum_o   (mac_sum)
    );

    assign c_we           = vld_q & last_q;
    assign sram_a_addr_o  = AddrWidth'(a_addr_full);
    assign sram_b_addr_o  = AddrWidth'(b_addr_full);
    // C address and data are held at zero outside write cycles.
    assign sram_c_addr_o  = c_we ? AddrWidth'(c_addr_full) : '0;
    assign sram_c_wdata_o = c_we ? mac_sum : '0;
    assign sram_c_we_o    = c_we;
    assign done_o         = (state_q == StDone);

endmodule

// File: tb/tb_gemm_one_mac_accelerator.sv
module tb_gemm_one_mac_accelerator;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  M_size_i;
    logic [7:0]  K_size_i;
    logic [7:0]  N_size_i;
    logic [11:0] sram_a_addr_o;
    logic [11:0] sram_b_addr_o;
    logic [11:0] sram_c_addr_o;
    logic [7:0]  sram_a_rdata_i;
    logic [7:0]  sram_b_rdata_i;
    logic [31:0] sram_c_wdata_o;
    logic        sram_c_we_o;
    logic        done_o;

    gemm_one_mac_accelerator u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .M_size_i       (M_size_i),
        .K_size_i       (K_size_i),
        .N_size_i       (N_size_i),
        .sram_a_addr_o  (sram_a_addr_o),
        .sram_b_addr_o  (sram_b_addr_o),
        .sram_c_addr_o  (sram_c_addr_o),
        .sram_a_rdata_i (sram_a_rdata_i),
        .sram_b_rdata_i (sram_b_rdata_i),
        .sram_c_wdata_o (sram_c_wdata_o),
        .sram_c_we_o    (sram_c_we_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read memory models for A and B.
    logic [7:0] mem_a [0:4095];
    logic [7:0] mem_b [0:4095];
    always @(posedge clk) begin
        sram_a_rdata_i <= mem_a[sram_a_addr_o];
        sram_b_rdata_i <= mem_b[sram_b_addr_o];
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr_q[$];
    int  exp_done_q[$];
    int  n_total  = 0;
    int  n_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every C write and done pulse against the scoreboard.
    wr_t mon_e;
    int  mon_d;
    always @(negedge clk) begin
        if (sram_c_we_o) begin
            if (exp_wr_q.size() == 0) begin
                check("c_write_unexpected", {20'd0, sram_c_addr_o}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_wr_q.pop_front();
                check("c_addr", {20'd0, sram_c_addr_o}, {20'd0, mon_e.addr});
                check("c_wdata", sram_c_wdata_o, mon_e.data);
            end
        end
        if (done_o) begin
            if (exp_done_q.size() == 0) begin
                check("done_unexpected", cyc, 32'hFFFF_FFFF);
            end else begin
                mon_d = exp_done_q.pop_front();
                check("done_cycle", cyc, mon_d);
            end
        end
    end

    task automatic push_wr(input int addr, input int data);
        wr_t e;
        e.addr = 12'(addr);
        e.data = data;
        exp_wr_q.push_back(e);
    endtask

    task automatic fill_random(input int na, input int nb);
        for (int i = 0; i < na; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < nb; i++) mem_b[i] = 8'($urandom);
    endtask

    task automatic push_golden(input int m_sz, input int k_sz, input int n_sz);
        int acc;
        for (int m = 0; m < m_sz; m++) begin
            for (int n = 0; n < n_sz; n++) begin
                acc = 0;
                for (int k = 0; k < k_sz; k++) begin
                    acc += int'($signed(mem_a[m*k_sz+k])) * int'($signed(mem_b[k*n_sz+n]));
                end
                push_wr(m*n_sz+n, acc);
            end
        end
    endtask

    // Starts one GEMM, optionally pokes start/sizes while busy, waits for done.
    task automatic run(input int m_sz, input int k_sz, input int n_sz, input bit poke);
        int  lat;
        int  c0;
        bit  seen;
        lat = (m_sz == 0 || k_sz == 0 || n_sz == 0) ? 1 : m_sz*n_sz*k_sz + 2;
        @(posedge clk); #1;
        start_i  = 1'b1;
        M_size_i = 8'(m_sz);
        K_size_i = 8'(k_sz);
        N_size_i = 8'(n_sz);
        c0 = cyc;
        exp_done_q.push_back(c0 + lat);
        @(posedge clk); #1;
        start_i = 1'b0;
        if (poke) begin
            start_i  = 1'b1;
            M_size_i = 8'd3;
            K_size_i = 8'd0;
            N_size_i = 8'd200;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < lat + 8 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a_addr"}, {20'd0, sram_a_addr_o}, 32'd0);
        check({tag, "_b_addr"}, {20'd0, sram_b_addr_o}, 32'd0);
        check({tag, "_c_addr"}, {20'd0, sram_c_addr_o}, 32'd0);
        check({tag, "_c_wdata"}, sram_c_wdata_o, 32'd0);
        check({tag, "_c_we"}, {31'd0, sram_c_we_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_sz;
        int k_sz;
        int n_sz;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        rst_i    = 1'b1;
        start_i  = 1'b0;
        M_size_i = 8'd0;
        K_size_i = 8'd0;
        N_size_i = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;

        // 1x1x1: 3 * -4 = -12, done at start+3
        mem_a[0] = 8'd3;
        mem_b[0] = 8'hFC;
        push_wr(0, -12);
        run(1, 1, 1, 1'b0);

        // 2x2x2: [1,2;3,4]*[5,6;7,8] = [19,22;43,50], done at start+10
        mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3; mem_a[3] = 8'd4;
        mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[2] = 8'd7; mem_b[3] = 8'd8;
        push_wr(0, 19);
        push_wr(1, 22);
        push_wr(2, 43);
        push_wr(3, 50);
        run(2, 2, 2, 1'b1);

        // 8x8x8 random signed data
        fill_random(64, 64);
        push_golden(8, 8, 8);
        run(8, 8, 8, 1'b0);

        // Extremes: K=32, every element -128 -> 32 * 16384 = 524288
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'h80;
            mem_b[i] = 8'h80;
        end
        for (int i = 0; i < 4; i++) push_wr(i, 524288);
        run(2, 32, 2, 1'b0);

        // Back-to-back random sizes, with start pokes while busy
        for (int r = 0; r < 10; r++) begin
            do begin
                m_sz = int'($urandom_range(1, 32));
                k_sz = int'($urandom_range(1, 32));
                n_sz = int'($urandom_range(1, 32));
            end while (m_sz * k_sz * n_sz > 4000);
            fill_random(m_sz * k_sz, k_sz * n_sz);
            push_golden(m_sz, k_sz, n_sz);
            run(m_sz, k_sz, n_sz, 1'b1);
        end

        // Reset mid-RUN: no writes or done expected from the aborted job
        mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3; mem_a[3] = 8'd4;
        mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[2] = 8'd7; mem_b[3] = 8'd8;
        @(posedge clk); #1;
        start_i  = 1'b1;
        M_size_i = 8'd2;
        K_size_i = 8'd2;
        N_size_i = 8'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_outputs_zero("midrst");
        repeat (6) @(posedge clk);

        // Recovery: 1x1x1 run after the abort
        mem_a[0] = 8'hF9;
        mem_b[0] = 8'd5;
        push_wr(0, -35);
        run(1, 1, 1, 1'b0);

        // Zero size: done one cycle after start, no writes
        run(0, 4, 3, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("writes_outstanding", exp_wr_q.size(), 32'd0);
        check("done_outstanding", exp_done_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
